// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Package : pipeline_hazard_ctrl_pkg
// Brief   : Shared types and ISA constants for the pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_LOAD = 3'b001;
  localparam logic [2:0] WB_PC4  = 3'b010;

  function automatic logic is_load_wbsel(input logic [2:0] wbsel);
    return wbsel == WB_LOAD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Interface : pipeline_hazard_ctrl_if
// Brief     : Hazard inputs from ID/EX/MEM and stall/flush/freeze controls back.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_ID;
  logic [REG_ADDR_W-1:0] rs2_ID;
  logic [REG_ADDR_W-1:0] rd_EX;
  logic                  memread_EX;
  logic                  redirect_EX;
  logic                  dmem_req;
  logic                  dmem_ready;
  logic                  pc_stall;
  logic                  ifid_stall;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  pipe_freeze;
  logic                  mem_err;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, memread_EX, redirect_EX, dmem_req, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_err
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, memread_EX, redirect_EX, dmem_req, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_err
  );

endinterface

`default_nettype wire

// File: rtl/hazard_loaduse_det.sv
// ============================================================================
// Module : hazard_loaduse_det
// Brief  : Combinational load-use detect: load in ID/EX writing a source of IF/ID.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_loaduse_det
  import pipeline_hazard_ctrl_pkg::*;
(
  input  wire logic                  i_memread,
  input  wire logic [REG_ADDR_W-1:0] i_rd,
  input  wire logic [REG_ADDR_W-1:0] i_rs1,
  input  wire logic [REG_ADDR_W-1:0] i_rs2,
  output logic                       o_hazard
);

  // x0 is never written, so a load targeting it cannot create a dependency
  assign o_hazard = i_memread && (i_rd != '0) && ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Stall/flush/freeze sequencer for the 5-stage RV32I pipeline.
//          Optional HAZARD_PERF_CNT_EN adds stall/flush/freeze cycle counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYC = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pipeline_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt,
  output logic [31:0]            perf_freeze_cnt
`endif
);

  localparam int                RCNT_W       = (REDIRECT_CYC > 1) ? $clog2(REDIRECT_CYC) : 1;
  localparam logic [RCNT_W-1:0] c_REDIR_LOAD = RCNT_W'(REDIRECT_CYC - 1);
  localparam logic [CNT_W-1:0]  c_TIMEOUT    = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  c_CNT_MAX    = {CNT_W{1'b1}};

  hazard_state_e     r_state;
  hazard_state_e     w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_nxt;
  logic [RCNT_W-1:0] r_redir_cnt;
  logic [RCNT_W-1:0] w_redir_nxt;
  logic              r_redir_pend;
  logic              w_pend_nxt;

  logic w_loaduse;
  logic w_mem_stall;
  logic w_timeout;
  logic w_eval;
  logic w_freeze;
  logic w_stall;
  logic w_flush;
  logic w_bubble;
  logic w_err;

  hazard_loaduse_det u_loaduse (
    .i_memread (bus.memread_EX),
    .i_rd      (bus.rd_EX),
    .i_rs1     (bus.rs1_ID),
    .i_rs2     (bus.rs2_ID),
    .o_hazard  (w_loaduse)
  );

  assign w_mem_stall = bus.dmem_req && !bus.dmem_ready;
  assign w_timeout   = (MEM_TIMEOUT != 0) && !bus.dmem_ready && (r_wait_cnt == c_TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_redir_nxt = r_redir_cnt;
    w_pend_nxt  = r_redir_pend;
    w_eval      = 1'b0;
    w_freeze    = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    w_err       = 1'b0;

    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_freeze    = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = CNT_W'(1);
        end else begin
          w_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready || w_timeout) begin
          w_err       = w_timeout;
          w_eval      = 1'b1;
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          w_freeze = 1'b1;
          w_stall  = 1'b1;
          if (r_wait_cnt != c_CNT_MAX) begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
      end
      REDIRECT: begin
        if (w_mem_stall) begin
          w_freeze    = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = CNT_W'(1);
        end else begin
          // Load-use is ignored here: the instruction in IF/ID is being flushed
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (bus.redirect_EX) begin
            w_redir_nxt = c_REDIR_LOAD;
          end else begin
            w_redir_nxt = r_redir_cnt - RCNT_W'(1);
            if (r_redir_cnt == RCNT_W'(1)) begin
              w_state_nxt = RUN;
            end
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_freeze && bus.redirect_EX) begin
      w_pend_nxt = 1'b1;
    end

    if (w_eval) begin
      if (bus.redirect_EX || r_redir_pend) begin
        w_flush    = 1'b1;
        w_bubble   = 1'b1;
        w_pend_nxt = 1'b0;
        if (REDIRECT_CYC > 1) begin
          w_state_nxt = REDIRECT;
          w_redir_nxt = c_REDIR_LOAD;
        end
      end else if (w_loaduse) begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_redir_cnt  <= '0;
      r_redir_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_redir_cnt  <= w_redir_nxt;
      r_redir_pend <= w_pend_nxt;
    end
  end

  assign bus.pc_stall    = !rst && w_stall;
  assign bus.ifid_stall  = !rst && w_stall && !w_flush;
  assign bus.ifid_flush  = !rst && w_flush;
  assign bus.idex_bubble = !rst && w_bubble;
  assign bus.pipe_freeze = !rst && w_freeze;
  assign bus.mem_err     = !rst && w_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall  <= '0;
      r_perf_flush  <= '0;
      r_perf_freeze <= '0;
    end else begin
      if (w_stall && !w_freeze) r_perf_stall  <= r_perf_stall + 32'd1;
      if (w_flush)              r_perf_flush  <= r_perf_flush + 32'd1;
      if (w_freeze)             r_perf_freeze <= r_perf_freeze + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_perf_stall;
  assign perf_flush_cnt  = r_perf_flush;
  assign perf_freeze_cnt = r_perf_freeze;
`endif

endmodule

`default_nettype wire
